decryption_seq: RTL
===================

// Module: decryption_seq
// PURPOSE
//  Iterative S-AES decryptor: inverse of the 2-round combinational encryption
//  datapath (AddKey0, SubNib, MixCol, AddKey1, SubNib, AddKey2; no ShiftRows).
//  Accepts one ciphertext plus three round keys over a valid/ready handshake,
//  recovers plaintext over multiple cycles through a shared inverse S-box, and
//  presents it on a valid/ready output. Sits on the receive side of the link.
// PARAMETERS
//  NIBS_PER_CYC  1  inverse S-box lanes used per cycle; legal 1, 2, 4 (SUB phase = 4/NIBS_PER_CYC cycles)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   cipher/keys valid
//  in_ready   out  1   block can accept (high only in IDLE)
//  cipher     in   16  ciphertext
//  key0       in   16  round key 0 (applied last)
//  key1       in   16  round key 1
//  key2       in   16  round key 2 (applied first)
//  out_valid  out  1   plain valid
//  out_ready  in   1   consumer accepts plain
//  plain      out  16  recovered plaintext
//  busy       out  1   high in any state except IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM->IDLE; in_ready=1, out_valid=0, busy=0, plain=0,
//   internal state/key regs=0, nibble counter=0. Reset mid-operation aborts silently.
//  Nibble order: n3=[15:12] n2=[11:8] n1=[7:4] n0=[3:0]; columns (n3,n2),(n1,n0).
//  InvSbox 0..F -> A 5 9 B 1 7 8 F 6 0 2 3 C 4 D E.
//  InvMix per column (a,b) -> (9a^2b, 2a^9b), GF(2^4) mod x^4+x+1.
//  FSM:
//   IDLE : in_ready=1. On in_valid&in_ready: st<=cipher^key2, latch key1,key0,
//          cnt<=0 -> SUB1. cipher/keys sampled only on this edge.
//   SUB1 : each cycle substitute NIBS_PER_CYC nibbles, highest index first
//          (n3 first); after 4/NIBS_PER_CYC cycles -> MIX.
//   MIX  : st<=InvMix(st^key1), one cycle -> SUB2.
//   SUB2 : as SUB1 -> FIN.
//   FIN  : plain<=st^key0, out_valid<=1 -> DONE.
//   DONE : hold plain and out_valid stable; on out_ready -> IDLE, out_valid<=0.
//  Latency: out_valid rises 2+2*(4/NIBS_PER_CYC) clocks after input handshake
//   edge (10 for N=1, 4 for N=4). One transaction in flight; in_ready=0 from
//   accept until the cycle after output handshake (no overlap, no bypass).
//  in_valid while busy is ignored (no latch, no error). out_ready outside DONE
//   is ignored. out_valid held indefinitely if out_ready stays low.
//  Invalid NIBS_PER_CYC: elaboration error.
//  All datapath widths 16 bits; GF multiply results are 4 bits, no overflow.
// TESTING
//  T1 cipher=0000,k0=k1=k2=0000 -> plain=9999, out_valid 10 clks after accept (N=1).
//  T2 cipher=1234,k2=1234,k1=0000,k0=FFFF -> plain=6666.
//  T3 cipher=0000,k2=0000,k1=AAAA,k0=0000 -> plain=AAAA.
//  T4 hold out_ready=0 for 20 clks after T1 -> plain/out_valid stable, in_ready=0,
//     second in_valid ignored; then out_ready=1 -> IDLE, next input accepted.
//  T5 assert rst_n=0 during SUB2 -> outputs to reset values immediately; next
//     transaction (T1 vector) completes correctly.
//  T6 repeat T1-T3 with NIBS_PER_CYC=2 and 4 -> same plaintexts, latency 6 and 4;
//     plus 1000 random vectors vs encryption model round-trip.

Source files
------------

// File: rtl/decryption_seq.sv
// decryption_seq: iterative S-AES decryptor (inverse of AddKey0/SubNib/MixCol/AddKey1/SubNib/AddKey2).
// Shares NIBS_PER_CYC inverse S-box lanes across both substitution phases.
`default_nettype none

module decryption_seq #(
  parameter int NIBS_PER_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] cipher,
  input  logic [15:0] key0,
  input  logic [15:0] key1,
  input  logic [15:0] key2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] plain,
  output logic        busy
);

  generate
    if (NIBS_PER_CYC != 1 && NIBS_PER_CYC != 2 && NIBS_PER_CYC != 4) begin : g_bad_param
      $error("decryption_seq: NIBS_PER_CYC must be 1, 2 or 4");
    end
  endgenerate

  localparam int SUB_CYCLES = 4 / NIBS_PER_CYC;
  localparam logic [1:0] LAST_CNT = 2'(SUB_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SUB1 = 3'd1,
    MIX  = 3'd2,
    SUB2 = 3'd3,
    FIN  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      state;
  logic [15:0] st;
  logic [15:0] k1;
  logic [15:0] k0;
  logic [1:0]  cnt;
  logic [15:0] sub_next;
  logic [15:0] mix_in;
  logic [15:0] mix_next;
  logic [1:0]  idx;

  function automatic logic [3:0] inv_sbox(input logic [3:0] n);
    case (n)
      4'h0: inv_sbox = 4'hA;  4'h1: inv_sbox = 4'h5;
      4'h2: inv_sbox = 4'h9;  4'h3: inv_sbox = 4'hB;
      4'h4: inv_sbox = 4'h1;  4'h5: inv_sbox = 4'h7;
      4'h6: inv_sbox = 4'h8;  4'h7: inv_sbox = 4'hF;
      4'h8: inv_sbox = 4'h6;  4'h9: inv_sbox = 4'h0;
      4'hA: inv_sbox = 4'h2;  4'hB: inv_sbox = 4'h3;
      4'hC: inv_sbox = 4'hC;  4'hD: inv_sbox = 4'h4;
      4'hE: inv_sbox = 4'hD;  default: inv_sbox = 4'hE;
    endcase
  endfunction

  // Multiply by x in GF(2^4) reduced by x^4+x+1.
  function automatic logic [3:0] mul2(input logic [3:0] a);
    mul2 = {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] mul9(input logic [3:0] a);
    mul9 = mul2(mul2(mul2(a))) ^ a;
  endfunction

  function automatic logic [7:0] inv_mix(input logic [7:0] col);
    inv_mix = {mul9(col[7:4]) ^ mul2(col[3:0]), mul2(col[7:4]) ^ mul9(col[3:0])};
  endfunction

  // Lane j of count step c works on nibble 3-(c*N+j): n3 goes first.
  always_comb begin
    sub_next = st;
    idx      = 2'd0;
    for (int j = 0; j < NIBS_PER_CYC; j++) begin
      idx = 2'd3 - 2'(int'(cnt) * NIBS_PER_CYC + j);
      sub_next[idx*4 +: 4] = inv_sbox(st[idx*4 +: 4]);
    end
  end

  assign mix_in   = st ^ k1;
  assign mix_next = {inv_mix(mix_in[15:8]), inv_mix(mix_in[7:0])};

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      st        <= 16'h0000;
      k1        <= 16'h0000;
      k0        <= 16'h0000;
      cnt       <= 2'd0;
      plain     <= 16'h0000;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st    <= cipher ^ key2;
            k1    <= key1;
            k0    <= key0;
            cnt   <= 2'd0;
            state <= SUB1;
          end
        end
        SUB1, SUB2: begin
          st <= sub_next;
          if (cnt == LAST_CNT) begin
            cnt   <= 2'd0;
            state <= (state == SUB1) ? MIX : FIN;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        MIX: begin
          st    <= mix_next;
          state <= SUB2;
        end
        FIN: begin
          plain     <= st ^ k0;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
